// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: shared FSM state and reset-cause encodings for the reset sequencer.
package reset_sequencer_pkg;
  typedef enum logic [1:0] {ST_SYNC, ST_HOLD, ST_RELEASE, ST_RUN} state_e;
  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;
endpackage

// File: rtl/reset_sequencer_sync.sv
// reset_sync: SYNC_STAGES-deep deassertion synchroniser with async active-low clear.
module reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_sync,
  output logic o_sync_next
);
  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  if (SYNC_STAGES < 2 || SYNC_STAGES > 8) begin : g_bad_stages
    $error("reset_sync: SYNC_STAGES out of range 2..8");
  end
  always_comb chain_d = {chain_q[SYNC_STAGES-2:0], 1'b1};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) chain_q <= '0;
    else chain_q <= chain_d;
  // o_sync_next is high on the edge where the last stage turns high
  assign o_sync      = chain_q[SYNC_STAGES-1];
  assign o_sync_next = chain_d[SYNC_STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged multi-domain reset release with POR/SW causes;
// define RESET_SEQ_WDT_EN to add the i_wdt_bite watchdog reset input.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_DOMAINS = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_sw_rst_req,
`ifdef RESET_SEQ_WDT_EN
  input  logic                   i_wdt_bite,
`endif
  output logic [NUM_DOMAINS-1:0] o_rst_n,
  output logic                   o_rst_done,
  output logic [1:0]             o_rst_cause
);
  localparam int CNT_MAX = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = GAP_CYCLES == 0 ? '0 : CW'(GAP_CYCLES - 1);
  localparam bit ALL_AT_ONCE = GAP_CYCLES == 0 || NUM_DOMAINS == 1;
  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 16) begin : g_bad_nd
    $error("reset_sequencer: NUM_DOMAINS out of range 1..16");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES out of range 1..255");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("reset_sequencer: GAP_CYCLES out of range 0..255");
  end
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic                   done_q, done_d;
  logic [1:0]             cause_q, cause_d;
  logic                   sync, sync_next, wdt;
`ifdef RESET_SEQ_WDT_EN
  assign wdt = i_wdt_bite;
`else
  assign wdt = 1'b0;
`endif
  reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .o_sync     (sync),
    .o_sync_next(sync_next)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_n_d = rst_n_q;
    cause_d = cause_q;
    case (state_q)
      ST_SYNC: state_d = sync_next || sync ? ST_HOLD : ST_SYNC;
      ST_HOLD:
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          rst_n_d = ALL_AT_ONCE ? '1 : NUM_DOMAINS'(1);
          state_d = ALL_AT_ONCE ? ST_RUN : ST_RELEASE;
        end else cnt_d = cnt_q + 1'b1;
      ST_RELEASE:
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          rst_n_d = (rst_n_q << 1) | NUM_DOMAINS'(1);
          state_d = &rst_n_d ? ST_RUN : ST_RELEASE;
        end else cnt_d = cnt_q + 1'b1;
      default:
        if (wdt || i_sw_rst_req) begin
          cnt_d   = '0;
          rst_n_d = '0;
          cause_d = wdt ? CAUSE_WDT : CAUSE_SW;
          state_d = ST_HOLD;
        end
    endcase
    done_d = state_d == ST_RUN;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= ST_SYNC;
      cnt_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  assign o_rst_n     = rst_n_q;
  assign o_rst_done  = done_q;
  assign o_rst_cause = cause_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: table vectors, directed corner sequences and a random
// request stream checked against an edge-arithmetic reference model.
module tb_reset_sequencer;
  localparam int N = 3, S = 2, H = 4, G = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0, sw = 1'b0, wdt = 1'b0;
  logic rst2_n = 1'b0, sw2 = 1'b0;
  logic [N-1:0] o_rst_n, o_rst_n2;
  logic o_done, o_done2;
  logic [1:0] o_cause, o_cause2;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  reset_sequencer #(.NUM_DOMAINS(N), .SYNC_STAGES(S), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_rst_req(sw),
`ifdef RESET_SEQ_WDT_EN
    .i_wdt_bite(wdt),
`endif
    .o_rst_n(o_rst_n), .o_rst_done(o_done), .o_rst_cause(o_cause));
  reset_sequencer #(.NUM_DOMAINS(N), .SYNC_STAGES(S), .HOLD_CYCLES(H), .GAP_CYCLES(0)) dut_g0 (
    .i_clk(clk), .i_rst_n(rst2_n), .i_sw_rst_req(sw2),
`ifdef RESET_SEQ_WDT_EN
    .i_wdt_bite(1'b0),
`endif
    .o_rst_n(o_rst_n2), .o_rst_done(o_done2), .o_rst_cause(o_cause2));
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask
  // Reference model: n counts edges since reset release; domain k is free once n >= rel0 + k*G.
  int n, rel0;
  logic [1:0] m_cause;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n <= 0;
      rel0 <= S + H;
      m_cause <= 2'b00;
    end else begin
      n <= n + 1;
      if (n >= rel0 + (N - 1) * G && (sw || wdt)) begin
        rel0 <= n + 1 + H;
        m_cause <= wdt ? 2'b10 : 2'b01;
      end
    end
  always @(negedge clk) begin
    logic [N-1:0] e;
    for (int k = 0; k < N; k++) e[k] = n >= rel0 + k * G;
    check("model_rst_n", int'(o_rst_n), int'(e));
    check("model_done", int'(o_done), int'(n >= rel0 + (N - 1) * G));
    check("model_cause", int'(o_cause), int'(m_cause));
  end
  typedef struct { logic [N-1:0] rst_n; logic done; logic [1:0] cause; } vec_t;
  vec_t por_tab[11];
  task automatic run_por_table(input string tag);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check({tag, "_rst_n"}, int'(o_rst_n), int'(por_tab[i].rst_n));
      check({tag, "_done"}, int'(o_done), int'(por_tab[i].done));
      check({tag, "_cause"}, int'(o_cause), int'(por_tab[i].cause));
    end
  endtask
  task automatic req_seq(input string tag, input logic use_wdt, input logic [1:0] exp_cause);
    @(negedge clk);
    sw = 1'b1;
    wdt = use_wdt;
    @(negedge clk);
    sw = 1'b0;
    wdt = 1'b0;
    check({tag, "_E_rst_n"}, int'(o_rst_n), 0);
    check({tag, "_E_done"}, int'(o_done), 0);
    check({tag, "_E_cause"}, int'(o_cause), int'(exp_cause));
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      check($sformatf("%s_E+%0d", tag, j), int'(o_rst_n),
            j >= 8 ? 7 : j >= 6 ? 3 : j >= 4 ? 1 : 0);
    end
    check({tag, "_done"}, int'(o_done), 1);
  endtask
  initial begin
    por_tab = '{'{3'b000, 1'b0, 2'b00}, '{3'b000, 1'b0, 2'b00}, '{3'b000, 1'b0, 2'b00},
                '{3'b000, 1'b0, 2'b00}, '{3'b000, 1'b0, 2'b00}, '{3'b001, 1'b0, 2'b00},
                '{3'b001, 1'b0, 2'b00}, '{3'b011, 1'b0, 2'b00}, '{3'b011, 1'b0, 2'b00},
                '{3'b111, 1'b1, 2'b00}, '{3'b111, 1'b1, 2'b00}};
    repeat (2) @(negedge clk);
    check("reset_rst_n", int'(o_rst_n), 0);
    check("reset_done", int'(o_done), 0);
    check("reset_cause", int'(o_cause), 0);
    rst_n = 1'b1;
    run_por_table("por");
    req_seq("sw", 1'b0, 2'b01);
    check("sw_cause_hold", int'(o_cause), 1);
`ifdef RESET_SEQ_WDT_EN
    req_seq("wdt", 1'b1, 2'b10);
`endif
    // Abort mid-release, then the full schedule must repeat.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("abort_async_rst_n", int'(o_rst_n), 0);
    check("abort_async_done", int'(o_done), 0);
    check("abort_async_cause", int'(o_cause), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_por_table("abort");
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      sw = $urandom_range(0, 5) == 0;
`ifdef RESET_SEQ_WDT_EN
      wdt = $urandom_range(0, 9) == 0;
`endif
    end
    @(negedge clk);
    sw = 1'b0;
    wdt = 1'b0;
    // GAP_CYCLES=0 instance: simultaneous release, requests ignored in HOLD.
    rst2_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check($sformatf("g0_edge%0d", i), int'(o_rst_n2), i == 6 ? 7 : 0);
    end
    check("g0_done", int'(o_done2), 1);
    @(negedge clk);
    sw2 = 1'b1;
    @(negedge clk);
    sw2 = 1'b0;
    check("g0_sw_E", int'(o_rst_n2), 0);
    check("g0_sw_cause", int'(o_cause2), 1);
    @(negedge clk);
    sw2 = 1'b1;
    @(negedge clk);
    sw2 = 1'b0;
    @(negedge clk);
    check("g0_hold_E+3", int'(o_rst_n2), 0);
    @(negedge clk);
    check("g0_hold_E+4", int'(o_rst_n2), 7);
    check("g0_hold_done", int'(o_done2), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
